// File: rtl/rle_stream_scheduler.sv
// rle_stream_scheduler
// Shares one RLE decoder between NUM_REQ filter channels. A round-robin
// arbiter picks a pending 3-word run-length packet and latches it onto the
// decoder stream inputs. The block then strobes the decoder's new-image load
// and gates the decoder enable for exactly the packet's total run length,
// stalling while the downstream FIFO reports full.
module rle_stream_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int WORD_W  = 13
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*3*WORD_W-1:0] req_stream,
  output logic [NUM_REQ-1:0]          req_ack,
  input  logic                        fifo_full,
  output logic [WORD_W-1:0]           dec_stream1,
  output logic [WORD_W-1:0]           dec_stream2,
  output logic [WORD_W-1:0]           dec_stream3,
  output logic                        dec_new_im,
  output logic                        dec_enable,
  output logic [2:0]                  grant_id,
  output logic                        busy,
  output logic                        pkt_done
);

  // Three words of WORD_W bits sum without overflow in WORD_W+2 bits.
  localparam int CNT_W = WORD_W + 2;
  localparam int PKT_W = 3 * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   s1_q, s1_d;
  logic [WORD_W-1:0]   s2_q, s2_d;
  logic [WORD_W-1:0]   s3_q, s3_d;
  logic [2:0]          grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                new_im_q, new_im_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [2*NUM_REQ-1:0] dbl_valid_s;
  logic [NUM_REQ-1:0]   rot_valid_s;
  logic                 sel_found_s;
  logic [2:0]           sel_idx_s;
  logic [PKT_W-1:0]     sel_pkt_s;
  logic [CNT_W-1:0]     sel_sum_s;

  // Round-robin pick: rotate the request vector so the pointer sits at bit 0,
  // then take the lowest set bit and map it back to a channel index.
  always_comb begin
    dbl_valid_s = {req_valid, req_valid};
    rot_valid_s = NUM_REQ'(dbl_valid_s >> ptr_q);
    sel_found_s = 1'b0;
    sel_idx_s   = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_idx_s   = (!sel_found_s && rot_valid_s[i]) ? 3'((int'(ptr_q) + i) % NUM_REQ) : sel_idx_s;
      sel_found_s = sel_found_s | rot_valid_s[i];
    end
    sel_pkt_s = PKT_W'(req_stream >> (int'(sel_idx_s) * PKT_W));
    sel_sum_s = CNT_W'(sel_pkt_s[WORD_W-1:0])
              + CNT_W'(sel_pkt_s[2*WORD_W-1:WORD_W])
              + CNT_W'(sel_pkt_s[3*WORD_W-1:2*WORD_W]);
  end

  // Next-state and next-output computation for the scheduling FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    grant_d = grant_q;
    ack_d   = {NUM_REQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          ack_d   = NUM_REQ'(1'b1) << sel_idx_s;
          s1_d    = sel_pkt_s[WORD_W-1:0];
          s2_d    = sel_pkt_s[2*WORD_W-1:WORD_W];
          s3_d    = sel_pkt_s[3*WORD_W-1:2*WORD_W];
          grant_d = sel_idx_s;
          ptr_d   = (sel_idx_s == 3'(NUM_REQ - 1)) ? 3'd0 : (sel_idx_s + 3'd1);
          cnt_d   = sel_sum_s;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_RUN: begin
        // A full FIFO freezes the count; there is deliberately no timeout.
        if (!fifo_full) begin
          cnt_d = cnt_q - CNT_W'(1'b1);
          if (cnt_q == CNT_W'(1'b1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          cnt_d   = cnt_q;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    new_im_d = (state_d == ST_LOAD);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  // State and registered outputs; reset aborts any packet in flight.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 3'd0;
      cnt_q    <= {CNT_W{1'b0}};
      s1_q     <= {WORD_W{1'b1}};
      s2_q     <= {WORD_W{1'b1}};
      s3_q     <= {WORD_W{1'b1}};
      grant_q  <= 3'd0;
      ack_q    <= {NUM_REQ{1'b0}};
      new_im_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      new_im_q <= new_im_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Decoder enable: forced during the load cycle, follows FIFO space in RUN.
  always_comb begin
    dec_enable = new_im_q | ((state_q == ST_RUN) & ~fifo_full);
  end

  assign req_ack     = ack_q;
  assign dec_stream1 = s1_q;
  assign dec_stream2 = s2_q;
  assign dec_stream3 = s3_q;
  assign dec_new_im  = new_im_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign pkt_done    = done_q;

endmodule
